multicycle_control: RTL and testbench

// Moore/Mealy FSM sequencing the multicycle MIPS datapath: shared instr/data memory, IR, MDR, A/B, ALUOut.

---
 rtl/multicycle_control.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: sequencer for the multicycle MIPS datapath.
// Decodes OP/Funct once per instruction (in DECODE), then walks the
// datapath through its per-instruction states, stalling on MemReady.
// Illegal opcodes and memory timeouts park the FSM in HALT with a sticky Fault.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   OP, Funct             instruction fields from IR (used in DECODE only)
//   Zero                  ALU zero flag, used in BRANCH
//   MemReady              memory completes the current access this cycle
//   IorD..RegWrite        datapath selects, ALU op and write enables
//   Fault                 sticky illegal-opcode / timeout flag
//   State                 current state code (debug)
module multicycle_control #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       Fault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXE    = 4'd6,
    R_WB     = 4'd7,
    I_EXE    = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b111;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;

  state_t           state, state_next;
  logic [5:0]       op_q, op_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next, wait_cnt_inc;
  logic             fault_q, fault_next;
  logic             wait_last;
  logic             ir_write, pc_write, reg_write, mem_write;

  // The low cycle that would bring the count to WAIT_LIMIT is the last one tolerated.
  assign wait_cnt_inc = wait_cnt + CNT_W'(1);
  assign wait_last    = (wait_cnt_inc == CNT_W'(WAIT_LIMIT));

  // State, latched opcode, wait counter and sticky fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      op_q     <= 6'd0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_next;
      op_q     <= op_next;
      wait_cnt <= wait_cnt_next;
      fault_q  <= fault_next;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next    = state;
    op_next       = op_q;
    wait_cnt_next = '0;
    fault_next    = fault_q;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    PCSource      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 3'b000;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    reg_write     = 1'b0;

    case (state)
      FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        ALUOp    = ALU_ADD;
        ir_write = MemReady;
        pc_write = MemReady;
        if (MemReady) begin
          state_next = DECODE;
        end else if (wait_last) begin
          state_next = HALT;
          fault_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        op_next = OP;
        case (OP)
          OP_RTYPE:                         state_next = (Funct == FN_JR) ? JR : R_EXE;
          OP_LW, OP_SW:                     state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_next = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = I_EXE;
          OP_J:                             state_next = JUMP;
          OP_JAL:                           state_next = JAL;
          default: begin
            state_next = HALT;
            fault_next = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = ALU_ADD;
        state_next = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD, MEM_WR: begin
        IorD      = 1'b1;
        MemRead   = (state == MEM_RD);
        mem_write = (state == MEM_WR);
        if (MemReady) begin
          state_next = (state == MEM_RD) ? MEM_WB : FETCH;
        end else if (wait_last) begin
          state_next = HALT;
          fault_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
      end
      MEM_WB: begin
        MemtoReg   = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      R_EXE: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_FUNCT;
        state_next = R_WB;
      end
      R_WB: begin
        RegDst     = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      I_EXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_ADDI: ALUOp = ALU_ADD;
          OP_ANDI: ALUOp = ALU_AND;
          default: ALUOp = ALU_OR;
        endcase
        state_next = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        PCSource   = 2'b01;
        pc_write   = (op_q == OP_BNE) ? ~Zero : Zero;
        state_next = FETCH;
      end
      JUMP: begin
        PCSource   = 2'b10;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        reg_write  = 1'b1;
        PCSource   = 2'b10;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      JR: begin
        PCSource   = 2'b11;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      // HALT and the unused code 14 hold with everything idle.
      default: state_next = HALT;
    endcase
  end

  // Write enables are squashed while reset is held so an aborted access never completes.
  assign IRWrite  = ir_write  & ~reset;
  assign PCWrite  = pc_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign Fault    = fault_q;
  assign State    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed instruction cases plus random
// instruction streams with random memory stalls, compared cycle by cycle against
// an instruction-level model (state sequence per instruction class + output table).
module tb_multicycle_control;

  localparam int unsigned WAIT_LIMIT = 16;
  localparam int unsigned CNT_W      = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP, Funct;
  logic       Zero, MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, ALUSrcA, RegWrite, Fault;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg;
  logic [2:0] ALUOp;
  logic [3:0] State;
  logic [17:0] obs;

  int checks   = 0;
  int failures = 0;
  logic exp_fault = 1'b0;

  multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  assign obs = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, ALUSrcA,
                ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected controls for each state, straight from the per-state control table.
  function automatic logic [17:0] exp_out(input int st, input logic [5:0] op,
                                          input logic mr, input logic z);
    logic iord, mrd, mwr, irw, pcw, srca, rw;
    logic [1:0] pcs, srcb, rdst, m2r;
    logic [2:0] aop;
    iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0; pcw = 1'b0; srca = 1'b0; rw = 1'b0;
    pcs = 2'b00; srcb = 2'b00; rdst = 2'b00; m2r = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mrd = 1'b1; srcb = 2'b01; aop = 3'b100; irw = mr; pcw = mr; end
      1:  begin srcb = 2'b11; aop = 3'b100; end
      2:  begin srca = 1'b1; srcb = 2'b10; aop = 3'b100; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin m2r = 2'b01; rw = 1'b1; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin srca = 1'b1; aop = 3'b111; end
      7:  begin rdst = 2'b01; rw = 1'b1; end
      8:  begin
            srca = 1'b1; srcb = 2'b10;
            aop = (op == 6'h08) ? 3'b100 : (op == 6'h0c) ? 3'b110 : 3'b101;
          end
      9:  rw = 1'b1;
      10: begin srca = 1'b1; aop = 3'b001; pcs = 2'b01; pcw = (op == 6'h05) ? ~z : z; end
      11: begin pcs = 2'b10; pcw = 1'b1; end
      12: begin rdst = 2'b10; m2r = 2'b10; rw = 1'b1; pcs = 2'b10; pcw = 1'b1; end
      13: begin pcs = 2'b11; pcw = 1'b1; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, pcw, pcs, srca, srcb, aop, rdst, m2r, rw};
  endfunction

  // One clock: drive inputs, compare at the falling edge, advance past the rising edge.
  task automatic step(input int st, input logic [5:0] op_now, input logic [5:0] fn_now,
                      input logic [5:0] op_instr, input logic mr, input logic z);
    OP = op_now; Funct = fn_now; MemReady = mr; Zero = z;
    @(negedge clk);
    check_eq($sformatf("state_in_st%0d", st), 32'(State), 32'(st));
    check_eq($sformatf("ctrl_in_st%0d", st), 32'(obs), 32'(exp_out(st, op_instr, mr, z)));
    check_eq($sformatf("fault_in_st%0d", st), 32'(Fault), 32'(exp_fault));
    @(posedge clk); #1;
  endtask

  // Same, with OP/Funct scrambled to show they only matter in DECODE.
  task automatic step_j(input int st, input logic [5:0] op_instr, input logic mr, input logic z);
    step(st, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), op_instr, mr, z);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    reset = 1'b1; MemReady = 1'b1; Zero = rbit(); OP = 6'($urandom_range(0, 63));
    @(negedge clk);
    check_eq("reset_state", 32'(State), 32'd0);
    check_eq("reset_fault", 32'(Fault), 32'd0);
    check_eq("reset_enables", 32'({IRWrite, PCWrite, RegWrite, MemWrite}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_fault = 1'b0;
  endtask

  // A few cycles parked in HALT, then recover through reset.
  task automatic halt_check();
    for (int i = 0; i < 3; i++) step_j(15, 6'h00, rbit(), rbit());
    do_reset();
  endtask

  // Memory phase: w low cycles then ready, or timeout after WAIT_LIMIT low cycles.
  task automatic mem_phase(input int st, input logic [5:0] op_instr, input int w, output bit ok);
    int lows;
    lows = (w >= int'(WAIT_LIMIT)) ? int'(WAIT_LIMIT) : w;
    for (int i = 0; i < lows; i++) step_j(st, op_instr, 1'b0, rbit());
    if (w >= int'(WAIT_LIMIT)) begin
      exp_fault = 1'b1;
      ok = 1'b0;
    end else begin
      step_j(st, op_instr, 1'b1, rbit());
      ok = 1'b1;
    end
  endtask

  // Whole instruction: fetch with fw stall cycles, decode, class-specific states.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    bit ok;
    mem_phase(0, op, fw, ok);
    if (!ok) begin halt_check(); return; end
    step(1, op, fn, op, rbit(), rbit());
    if (op == 6'h00 && fn == 6'h08) step_j(13, op, rbit(), rbit());
    else if (op == 6'h00) begin step_j(6, op, rbit(), rbit()); step_j(7, op, rbit(), rbit()); end
    else if (op == 6'h23) begin
      step_j(2, op, rbit(), rbit());
      mem_phase(3, op, mw, ok);
      if (!ok) halt_check(); else step_j(4, op, rbit(), rbit());
    end
    else if (op == 6'h2b) begin
      step_j(2, op, rbit(), rbit());
      mem_phase(5, op, mw, ok);
      if (!ok) halt_check();
    end
    else if (op == 6'h04 || op == 6'h05) step_j(10, op, rbit(), z);
    else if (op == 6'h08 || op == 6'h0c || op == 6'h0d || op == 6'h0f) begin
      step_j(8, op, rbit(), rbit()); step_j(9, op, rbit(), rbit());
    end
    else if (op == 6'h02) step_j(11, op, rbit(), rbit());
    else if (op == 6'h03) step_j(12, op, rbit(), rbit());
    else begin
      exp_fault = 1'b1;
      halt_check();
    end
  endtask

  // Reset pulse in the middle of a stalled store.
  task automatic reset_during_store();
    bit ok;
    mem_phase(0, 6'h2b, 0, ok);
    step(1, 6'h2b, 6'h00, 6'h2b, 1'b0, 1'b0);
    step_j(2, 6'h2b, 1'b0, 1'b0);
    step_j(5, 6'h2b, 1'b0, 1'b0);
    MemReady = 1'b0;
    @(negedge clk);
    check_eq("store_write_held", 32'(MemWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("store_abort_write", 32'(MemWrite), 32'd0);
    check_eq("store_abort_state", 32'(State), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_fault = 1'b0;
    run_instr(6'h00, 6'h20, 1'b0, 2, 0);
  endtask

  logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05,
                              6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h02, 6'h03};

  initial begin
    logic [5:0] op, fn;
    int fw, mw;
    reset = 1'b1; OP = 6'h00; Funct = 6'h00; Zero = 1'b0; MemReady = 1'b0;
    do_reset();

    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // ADD
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // LW, 3 stall cycles in MEM_RD
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // BEQ taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // BNE not taken
    run_instr(6'h05, 6'h00, 1'b0, 1, 0);   // BNE taken
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // JAL
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // JR
    run_instr(6'h0f, 6'h00, 1'b0, 0, 0);   // LUI
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);   // illegal
    run_instr(6'h00, 6'h20, 1'b0, 16, 0);  // fetch timeout
    run_instr(6'h00, 6'h20, 1'b0, 15, 0);  // ready on the last tolerated cycle
    run_instr(6'h2b, 6'h00, 1'b0, 0, 15);
    run_instr(6'h23, 6'h00, 1'b0, 0, 16);  // load timeout
    reset_during_store();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
      else op = op_tab[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
      fw = ($urandom_range(0, 24) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 24) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      run_instr(op, fn, rbit(), fw, mw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
